melody_sequencer: RTL and testbench
===================================

// Module: melody_sequencer
// PURPOSE
//  Plays a song table through one shared square-wave tone generator on the buzzer pin.
//  Fetches 16-bit note entries from an external synchronous ROM; each entry is a frequency plus a duration.
//  Holds each note for a whole number of step ticks, then advances to the next entry.
//  Replaces one hard-coded tone divider per note plus a case table with a single phase-accumulator generator.
//  Sits between the song ROM and the top-level speaker output.
// PARAMETERS
//  CLK_HZ      50_000_000  system clock frequency (Hz)
//  TICK_CYCLES 6_500_000   clocks per step tick (130 ms at 50 MHz); must be >= 2
//  ADDR_W      7           ROM address width
//  SONG_LEN    100         number of entries; valid addresses 0..SONG_LEN-1; 1 <= SONG_LEN <= 2**ADDR_W
//  GAP_CYCLES  500_000     silent gap at end of each note (NOTE_GAP_EN only); must be < TICK_CYCLES
// PORTS
//  clk         in   1       system clock
//  rst         in   1       synchronous, active-high reset
//  start       in   1       1-cycle pulse: begin playback at entry 0 (ignored while busy)
//  stop        in   1       1-cycle pulse: abort playback
//  loop_en     in   1       1: wrap to entry 0 after last entry; sampled at end of last entry
//  rom_addr    out  ADDR_W  entry address to ROM
//  rom_data    in   16      entry data, valid 1 cycle after rom_addr (registered ROM)
//  busy        out  1       high while a song is playing
//  note_strobe out  1       1-cycle pulse when a new entry is loaded
//  speaker     out  1       square-wave output to buzzer
// BEHAVIOUR
//  Entry format: [15:13] dur = ticks-1 (1..8 ticks); [12:0] freq in Hz (0 = rest, max 8191).
//  Reset: FSM=IDLE; rom_addr=0, busy=0, note_strobe=0, speaker=0; accumulator and counters cleared.
//  FSM: IDLE -> FETCH -> WAIT -> PLAY -> (FETCH | IDLE).
//   IDLE : rom_addr=0, speaker=0. start=1 -> FETCH; busy goes high on the next cycle.
//   FETCH: drive rom_addr; -> WAIT.
//   WAIT : rom_data valid. Latch freq/dur; note_strobe=1 for this cycle; clear tick and cycle counters.
//          Clear accumulator; tone=0. -> PLAY.
//   PLAY : speaker=tone; rests hold 0. Stay for (dur+1)*TICK_CYCLES clocks exactly.
//          At the last clock of the note:
//          - addr < SONG_LEN-1: addr+1 -> FETCH.
//          - addr == SONG_LEN-1 and loop_en=1: addr=0 -> FETCH.
//          - else -> IDLE; busy=0 on the next cycle.
//  Inter-note overhead: exactly 2 cycles (FETCH+WAIT), with speaker=0.
//  Tone gen: 26-bit unsigned accumulator, HALF=CLK_HZ/2, evaluated every PLAY cycle:
//   if acc+freq >= HALF: acc <= acc+freq-HALF and tone toggles; else acc <= acc+freq.
//   Mean toggle rate is exactly 2*freq. freq=0 never toggles.
//   Sum computed at 27 bits, no overflow. freq must be < HALF.
//  stop=1 in any state: -> IDLE next cycle; speaker=0, busy=0, rom_addr=0.
//   stop takes priority over a simultaneous start: block stays in IDLE.
//  start while busy: ignored, no restart. rst mid-note: same as reset, no output glitch beyond 1 cycle.
//  rom_addr never exceeds SONG_LEN-1.
// CONFIGURATION
//  NOTE_GAP_EN defined: speaker forced 0 during the final GAP_CYCLES clocks of every PLAY note.
//   Makes repeated entries of the same pitch audibly distinct. Note length and timing are unchanged.
//  NOTE_GAP_EN undefined: no gap; consecutive same-pitch entries sound continuous except for the 2-cycle refetch.
//   GAP_CYCLES is unused.
// TESTING (bench: CLK_HZ=100_000, TICK_CYCLES=1000, SONG_LEN=4)
//  1. ROM[0]={3'd1,13'd1000}, start pulse.
//     -> rom_addr=0 next cycle; note_strobe 2 cycles after start.
//     -> speaker toggles every 50 clocks: 40 toggles in 2000 clocks; then rom_addr=1.
//  2. ROM[1]={3'd0,13'd0} (rest) -> speaker=0 for 1000 PLAY clocks; busy=1 throughout.
//  3. loop_en=0 -> after ROM[3] ends, busy=0 and rom_addr=0.
//     loop_en=1 -> note_strobe with rom_addr=0, busy stays 1.
//  4. stop mid-note -> next cycle busy=0, speaker=0.
//     start+stop in the same cycle from IDLE -> busy stays 0.
//     start while busy -> rom_addr sequence unchanged.
//  5. rst asserted mid-PLAY for 1 cycle -> all outputs at reset values the next cycle.
//     A new start replays from entry 0.
//  6. NOTE_GAP_EN, GAP_CYCLES=100, ROM[0..1]={3'd0,13'd1000} ->
//     speaker=0 in the final 100 clocks of each note; total note length is still 1000 clocks.

Source files
------------

// File: rtl/melody_sequencer.sv
// Song-table player: fetches {dur,freq} entries from a registered ROM and drives one
// phase-accumulator square-wave generator. Optional NOTE_GAP_EN silences the end of each note.
module melody_sequencer #(
    parameter int CLK_HZ      = 50_000_000,
    parameter int TICK_CYCLES = 6_500_000,
    parameter int ADDR_W      = 7,
    parameter int SONG_LEN    = 100,
    parameter int GAP_CYCLES  = 500_000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              stop,
    input  logic              loop_en,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [15:0]       rom_data,
    output logic              busy,
    output logic              note_strobe,
    output logic              speaker
);

    localparam int CYC_W = $clog2(TICK_CYCLES);
    localparam logic [26:0]       HALF      = 27'(CLK_HZ / 2);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(SONG_LEN - 1);
    localparam logic [CYC_W-1:0]  CYC_LAST  = CYC_W'(TICK_CYCLES - 1);

`ifdef NOTE_GAP_EN
    localparam int GAP_LEN = GAP_CYCLES;
`else
    // GAP_CYCLES has no effect without the gap option
    localparam int GAP_LEN = GAP_CYCLES - GAP_CYCLES;
`endif
    localparam logic [CYC_W:0] GAP_START = (CYC_W + 1)'(TICK_CYCLES - GAP_LEN);

    typedef enum logic [1:0] {
        S_IDLE,
        S_FETCH,
        S_WAIT,
        S_PLAY
    } state_t;

    state_t            state;
    logic [12:0]       freq;
    logic [2:0]        dur;
    logic [2:0]        tick_cnt;
    logic [CYC_W-1:0]  cyc_cnt;
    logic [25:0]       acc;
    logic              tone;

    logic [26:0]       sum;
    logic              wrap;
    logic [25:0]       acc_next;
    logic              last_clk;
    logic              gap_next;
    logic [CYC_W:0]    cyc_p1;

    always_comb begin
        sum      = {1'b0, acc} + {14'b0, freq};
        wrap     = (sum >= HALF);
        acc_next = wrap ? 26'(sum - HALF) : sum[25:0];
        last_clk = (tick_cnt == dur) && (cyc_cnt == CYC_LAST);
        cyc_p1   = {1'b0, cyc_cnt} + 1'b1;
        // Next PLAY cycle falls inside the silent tail of the note (never true without the option
        // except on the last clock, where the speaker is cleared anyway).
        gap_next = (tick_cnt == dur) && (cyc_p1 >= GAP_START);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= S_IDLE;
            rom_addr    <= '0;
            busy        <= 1'b0;
            note_strobe <= 1'b0;
            speaker     <= 1'b0;
            freq        <= '0;
            dur         <= '0;
            tick_cnt    <= '0;
            cyc_cnt     <= '0;
            acc         <= '0;
            tone        <= 1'b0;
        end else if (stop) begin
            state       <= S_IDLE;
            rom_addr    <= '0;
            busy        <= 1'b0;
            note_strobe <= 1'b0;
            speaker     <= 1'b0;
            tone        <= 1'b0;
        end else begin
            note_strobe <= 1'b0;
            case (state)
                S_IDLE: begin
                    rom_addr <= '0;
                    speaker  <= 1'b0;
                    if (start) begin
                        state <= S_FETCH;
                        busy  <= 1'b1;
                    end
                end
                S_FETCH: begin
                    state       <= S_WAIT;
                    note_strobe <= 1'b1;
                end
                S_WAIT: begin
                    freq     <= rom_data[12:0];
                    dur      <= rom_data[15:13];
                    tick_cnt <= '0;
                    cyc_cnt  <= '0;
                    acc      <= '0;
                    tone     <= 1'b0;
                    speaker  <= 1'b0;
                    state    <= S_PLAY;
                end
                S_PLAY: begin
                    acc <= acc_next;
                    if (wrap)
                        tone <= ~tone;
                    if (cyc_cnt == CYC_LAST) begin
                        cyc_cnt  <= '0;
                        tick_cnt <= tick_cnt + 3'd1;
                    end else begin
                        cyc_cnt <= cyc_cnt + 1'b1;
                    end
                    speaker <= (wrap ? ~tone : tone) & ~gap_next;
                    if (last_clk) begin
                        speaker <= 1'b0;
                        tone    <= 1'b0;
                        if (rom_addr < LAST_ADDR) begin
                            rom_addr <= rom_addr + 1'b1;
                            state    <= S_FETCH;
                        end else if (loop_en) begin
                            rom_addr <= '0;
                            state    <= S_FETCH;
                        end else begin
                            rom_addr <= '0;
                            busy     <= 1'b0;
                            state    <= S_IDLE;
                        end
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_melody_sequencer.sv
// Directed bench for melody_sequencer: table of song entries with hand-computed note timing,
// plus hand-written start/stop/reset sequences. Expectations follow NOTE_GAP_EN when defined.
module tb_melody_sequencer;

    logic        clk = 1'b0;
    logic        rst, start, stop, loop_en;
    logic [6:0]  rom_addr;
    logic [15:0] rom_data;
    logic        busy, note_strobe, speaker;

    logic [15:0] rom [0:127];

    int n_vec = 0;
    int n_err = 0;

    melody_sequencer #(
        .CLK_HZ(100_000),
        .TICK_CYCLES(1000),
        .ADDR_W(7),
        .SONG_LEN(4),
        .GAP_CYCLES(100)
    ) dut (
        .clk(clk),
        .rst(rst),
        .start(start),
        .stop(stop),
        .loop_en(loop_en),
        .rom_addr(rom_addr),
        .rom_data(rom_data),
        .busy(busy),
        .note_strobe(note_strobe),
        .speaker(speaker)
    );

    always #5 clk = ~clk;

    always_ff @(posedge clk) rom_data <= rom[rom_addr];

    typedef struct {
        logic [15:0] entry;
        int          period;
        int          toggles;
        int          last_hi;
        int          next_addr;
    } vec_t;

    vec_t tbl [4];

    task automatic chk(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    // Samples from one note_strobe to the next; index 0 is the strobe cycle itself.
    task automatic measure(input int budget, output int period, output int toggles,
                           output int last_hi, output int busy_low, output int timed_out);
        logic prev;
        prev      = speaker;
        period    = 0;
        toggles   = 0;
        last_hi   = -1;
        busy_low  = 0;
        timed_out = 1;
        while (period < budget) begin
            step();
            period++;
            if (speaker !== prev) toggles++;
            prev = speaker;
            if (note_strobe === 1'b1) begin
                timed_out = 0;
                break;
            end
            if (speaker === 1'b1) last_hi = period;
            if (busy !== 1'b1) busy_low++;
        end
    endtask

    task automatic wait_strobe(input string name, input int budget);
        int n;
        n = 0;
        while (note_strobe !== 1'b1 && n < budget) begin
            step();
            n++;
        end
        chk(name, int'(note_strobe === 1'b1), 1);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic pulse_stop();
        stop = 1'b1;
        step();
        stop = 1'b0;
    endtask

    initial begin
        int p, t, lh, bl, to, n, seen;

`ifdef NOTE_GAP_EN
        tbl[0] = '{{3'd1, 13'd1000}, 2002, 38, 1900, 1};
        tbl[1] = '{{3'd0, 13'd0},    1002,  0,   -1, 2};
        tbl[2] = '{{3'd0, 13'd2500}, 1002, 44,  880, 3};
        tbl[3] = '{{3'd2, 13'd333},  3002, 20, 2900, 0};
`else
        tbl[0] = '{{3'd1, 13'd1000}, 2002, 40, 2000, 1};
        tbl[1] = '{{3'd0, 13'd0},    1002,  0,   -1, 2};
        tbl[2] = '{{3'd0, 13'd2500}, 1002, 50, 1000, 3};
        tbl[3] = '{{3'd2, 13'd333},  3002, 20, 3000, 0};
`endif
        for (int unsigned i = 0; i < 128; i++) rom[i] = 16'h1FFF;
        for (int unsigned i = 0; i < 4; i++) rom[i] = tbl[i].entry;

        rst = 1'b1; start = 1'b0; stop = 1'b0; loop_en = 1'b1;
        repeat (3) step();
        rst = 1'b0;
        chk("reset_busy", int'(busy), 0);
        chk("reset_addr", int'(rom_addr), 0);
        chk("reset_speaker", int'(speaker), 0);
        chk("reset_strobe", int'(note_strobe), 0);

        // Start latency: FETCH one cycle after start, strobe one cycle later.
        pulse_start();
        chk("start_busy", int'(busy), 1);
        chk("start_addr", int'(rom_addr), 0);
        chk("start_strobe_early", int'(note_strobe), 0);
        step();
        chk("start_strobe", int'(note_strobe), 1);

        // Table: one full pass with loop_en=1, last entry wraps to entry 0.
        for (int unsigned i = 0; i < 4; i++) begin
            measure(5000, p, t, lh, bl, to);
            chk($sformatf("v%0d_timeout", i), to, 0);
            chk($sformatf("v%0d_period", i), p, tbl[i].period);
            chk($sformatf("v%0d_toggles", i), t, tbl[i].toggles);
            chk($sformatf("v%0d_last_hi", i), lh, tbl[i].last_hi);
            chk($sformatf("v%0d_busy_low", i), bl, 0);
            chk($sformatf("v%0d_next_addr", i), int'(rom_addr), tbl[i].next_addr);
        end
        chk("loop_busy", int'(busy), 1);

        // Second pass with loop_en=0 ends in IDLE after entry 3.
        loop_en = 1'b0;
        for (int unsigned i = 0; i < 3; i++) begin
            measure(5000, p, t, lh, bl, to);
            chk($sformatf("pass2_%0d_timeout", i), to, 0);
        end
        n = 0;
        while (busy === 1'b1 && n < 5000) begin
            step();
            n++;
        end
        chk("end_idle_cycles", n, 3001);
        chk("end_addr", int'(rom_addr), 0);
        chk("end_speaker", int'(speaker), 0);

        // stop mid-note while the speaker is high.
        pulse_start();
        wait_strobe("stop_seq_strobe", 10);
        repeat (70) step();
        chk("pre_stop_speaker", int'(speaker), 1);
        pulse_stop();
        chk("stop_busy", int'(busy), 0);
        chk("stop_speaker", int'(speaker), 0);
        chk("stop_addr", int'(rom_addr), 0);

        // start and stop together from IDLE: stop wins.
        start = 1'b1; stop = 1'b1;
        step();
        start = 1'b0; stop = 1'b0;
        seen = 0;
        for (int unsigned i = 0; i < 6; i++) begin
            if (busy !== 1'b0 || note_strobe !== 1'b0) seen++;
            step();
        end
        chk("start_stop_idle", seen, 0);

        // start while busy is ignored: note timing and address sequence unchanged.
        pulse_start();
        wait_strobe("rebusy_strobe", 10);
        repeat (300) step();
        pulse_start();
        measure(5000, p, t, lh, bl, to);
        chk("rebusy_period", p + 301, 2002);
        chk("rebusy_addr", int'(rom_addr), 1);
        pulse_stop();

        // Synchronous reset mid-PLAY, then replay from entry 0.
        pulse_start();
        wait_strobe("rst_seq_strobe", 10);
        repeat (70) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("rst_busy", int'(busy), 0);
        chk("rst_speaker", int'(speaker), 0);
        chk("rst_addr", int'(rom_addr), 0);
        chk("rst_strobe", int'(note_strobe), 0);
        pulse_start();
        wait_strobe("replay_strobe", 10);
        chk("replay_addr", int'(rom_addr), 0);
        measure(5000, p, t, lh, bl, to);
        chk("replay_period", p, 2002);
        chk("replay_next_addr", int'(rom_addr), 1);
        pulse_stop();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, got timeout expected completion");
        $fatal(1);
    end

endmodule
